// File: rtl/alu_result_demux.sv
// alu_result_demux: registered 1-to-7 demux with discard sink.
// One-entry hold stage, valid/ready handshake, saturating counters.
module alu_result_demux #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [2:0]           in_index,
  output logic [6:0]           out_valid,
  input  logic [6:0]           out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] deliver_count,
  output logic [CNT_WIDTH-1:0] discard_count
);

  localparam logic [2:0] IDX_DISCARD = 3'd7;

  logic                 r_hold_valid;
  logic [2:0]           r_hold_index;
  logic [WIDTH-1:0]     r_hold_data;
  logic [CNT_WIDTH-1:0] r_deliver;
  logic [CNT_WIDTH-1:0] r_discard;

  logic [7:0] w_ready_ext;
  logic [7:0] w_onehot;
  logic       w_fire_out;
  logic       w_accept;
  logic       w_load;
  logic       w_drop;

  // Slot 7 never holds a word, so its ready reads as zero.
  assign w_ready_ext = {1'b0, out_ready};
  assign w_fire_out  = r_hold_valid && w_ready_ext[r_hold_index];
  assign in_ready    = !reset && (!r_hold_valid || w_fire_out);
  assign w_accept    = in_valid && in_ready;
  assign w_load      = w_accept && (in_index != IDX_DISCARD);
  assign w_drop      = w_accept && (in_index == IDX_DISCARD);

  assign w_onehot  = 8'd1 << r_hold_index;
  assign out_valid = r_hold_valid ? w_onehot[6:0] : 7'd0;
  assign out_data  = r_hold_data;

  assign deliver_count = r_deliver;
  assign discard_count = r_discard;

  // Hold register: load on a channel accept, clear on delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_index <= 3'd0;
      r_hold_data  <= '0;
    end else if (w_load) begin
      r_hold_valid <= 1'b1;
      r_hold_index <= in_index;
      r_hold_data  <= in_data;
    end else if (w_fire_out) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Delivered-word counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deliver <= '0;
    end else if (w_fire_out && (r_deliver != '1)) begin
      r_deliver <= r_deliver + 1'b1;
    end
  end

  // Discarded-word counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_discard <= '0;
    end else if (w_drop && (r_discard != '1)) begin
      r_discard <= r_discard + 1'b1;
    end
  end

endmodule

// File: doc/alu_result_demux.md
Name: alu_result_demux

Overview:
Registered 1-to-7 demultiplexer with a discard sink, the write-side counterpart of the ALU result multiplexer. Takes one WIDTH-bit word plus a 3-bit destination index per transfer and delivers it to exactly one of seven consumer channels over a valid/ready handshake. Index 7 is the discard sink, mirroring the constant-zero slot on the select side. Sits between the ALU result bus and the write-back consumers (register file port, flags, debug taps).

Parameters:
WIDTH, 32, data word width in bits
CNT_WIDTH, 8, width of the saturating delivered/discard counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  word to route
in_index  input  3  destination: 0-6 channel, 7 discard
out_valid  output  7  one-hot per-channel valid
out_ready  input  7  per-channel ready
out_data  output  WIDTH  shared data bus to all channels
deliver_count  output  CNT_WIDTH  words delivered on any channel, saturating
discard_count  output  CNT_WIDTH  words sent to index 7, saturating

Behaviour:
- Clock clk; reset synchronous and active-high, sampled on the rising edge.
- State: one-entry holding register (hold_valid, hold_index[2:0], hold_data).
- Reset: hold_valid=0, hold_index=0, hold_data=0, both counters=0, so out_valid=7'b0 and out_data=0. in_ready=0 while reset is high.
- out_valid[k] = hold_valid && hold_index==k, for k=0..6. At most one bit is set.
- out_data = hold_data. Retains its last value when hold_valid=0.
- fire_out = hold_valid && out_ready[hold_index]. in_ready = !reset && (!hold_valid || fire_out).
- accept = in_valid && in_ready.
- accept with in_index 0-6: load hold_* on that edge; out_valid is asserted the next cycle (latency 1).
- accept with in_index 7: do not load; increment discard_count. hold_valid clears if fire_out, else keeps its value.
- fire_out: increment deliver_count. hold_valid clears unless a 0-6 word is loaded on the same edge.
- Simultaneous fire_out and accept: pass-through, full throughput of one word per cycle to ready channels.
- Stall: while hold_valid && !out_ready[hold_index], out_valid, out_data and hold_index are stable and in_ready=0.
- out_ready bits for non-addressed channels are ignored. No cross-channel delivery.
- Counters saturate at all-ones; no wrap.
- Reset mid-stall: the held word is dropped, not counted, and in_ready rises the first cycle reset is low.
- in_data and in_index are ignored when in_valid=0.

Test Plan:
- Reset held 2 cycles, then released -> out_valid=0, out_data=0, counters=0, in_ready=1 in the first cycle after release.
- Send 0xDEADBEEF to index 3 with out_ready=7'h7F -> out_valid=7'b0001000 and out_data=0xDEADBEEF one cycle later; deliver_count=1.
- Back-to-back words to indices 0,1,2,…,6 with all ready -> one delivery per cycle in order; deliver_count=7; in_ready stays 1.
- Word to index 5 with out_ready[5]=0 for 4 cycles and all other ready bits 1 -> out_valid[5] and data held 4 cycles, in_ready=0; second word accepted on the cycle out_ready[5] rises.
- 300 words to index 7 -> no out_valid ever asserted; discard_count saturates at 255; deliver_count=0.
- Stall on index 2, then assert reset for 1 cycle -> out_valid clears, held word never delivered, deliver_count=0.
